td4_run_ctrl: RTL and testbench
===============================

Name: td4_run_ctrl

Overview:
- Execution and program-load controller for the 4-bit TD4 CPU core inside the tt_um_TD4_Assy_KosugiSubaru top level.
- Owns the CPU clock-enable and the CPU soft reset.
- Sequences byte-wise program loading into the 16x8 program memory over a valid/ready handshake.
- Provides halt / single-step / free-run (divided rate) execution modes selected from dedicated input pins.

Parameters:
- DIV_W, 20, width of run-rate divider; in RUN, one CPU step per 2^DIV_W clk cycles.
- DEPTH, 16, program memory words; loader address wraps at DEPTH-1.
- AW, 4, program memory address width (clog2 of DEPTH).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design-selected; when low, cpu_ce is forced 0 and all FSM/counter state holds.
- mode  in  2  00 HALT, 01 STEP, 10 RUN, 11 LOAD; synchronous level, sampled every clk.
- step_btn  in  1  step request, already synchronised; acts on its rising edge only.
- ld_valid  in  1  load byte valid.
- ld_data  in  8  load byte.
- ld_ready  out  1  controller accepts a byte this cycle.
- mem_we  out  1  program memory write strobe, one cycle per accepted byte.
- mem_addr  out  AW  program memory write address.
- mem_wdata  out  8  program memory write data.
- cpu_ce  out  1  CPU clock-enable; the CPU advances one instruction per high cycle.
- cpu_rst_n  out  1  CPU soft reset, active low.
- state_o  out  2  current state: 0 HALT, 1 STEP, 2 RUN, 3 LOAD.

Behaviour:
- Reset (async assert, sync deassert by clk) gives:
  - state = HALT.
  - ld_ready = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - cpu_ce = 0, cpu_rst_n = 0, state_o = 0.
  - Divider = 0, step edge register = 0, load address = 0.
- All outputs are registered.
- State transitions take effect the cycle after mode changes. Any state can go to any mode-selected state directly.
- HALT:
  - cpu_ce = 0, cpu_rst_n = 1.
  - Divider cleared.
- STEP:
  - A rising edge of step_btn gives cpu_ce = 1 for exactly one cycle, one cycle after the edge.
  - A held button gives no further pulses.
  - Edges while ena = 0 are ignored. The edge register still tracks step_btn.
- RUN:
  - Divider increments every ena cycle.
  - When the divider equals all-ones, cpu_ce = 1 for the following cycle and the divider wraps to 0.
  - Entering RUN clears the divider, so the first pulse comes 2^DIV_W cycles after entry.
- LOAD:
  - On entry: cpu_rst_n = 0, load address = 0, ld_ready = 1.
  - Each cycle with ld_valid & ld_ready:
    - mem_we = 1 next cycle, with mem_addr = current address and mem_wdata = ld_data.
    - Address increments, wrapping DEPTH-1 to 0. A 17th byte overwrites word 0.
  - ld_ready stays 1 continuously in LOAD, giving throughput of one byte per cycle.
  - While ld_ready = 0, ld_valid is ignored.
- Leaving LOAD:
  - ld_ready drops in the same cycle the state changes.
  - A byte handshaked on the last LOAD cycle is still written.
  - cpu_rst_n stays 0 for one more cycle after leaving LOAD, then rises. The CPU therefore restarts from PC 0.
  - mem_we in non-LOAD states is 0, apart from that trailing write.
- Precedence: ena = 0 overrides everything: cpu_ce = 0, mem_we = 0, ld_ready = 0. State is frozen; a mode change is taken when ena returns.
- Reset mid-load: address returns to 0, and that partial load is discarded from the controller's view. Memory contents are not cleared.

Test Plan:
- Reset: hold rst_n = 0 with mode = 10 -> cpu_ce = 0, cpu_rst_n = 0, ld_ready = 0, state_o = 0. After release -> state_o = 2 one cycle later.
- Load: mode = 11, then 16 back-to-back bytes 0x30..0x3F -> mem_we high 16 consecutive cycles, mem_addr 0..15 with matching wdata. Then a 17th byte 0xAA -> addr 0, data 0xAA.
- Load handshake gaps: ld_valid toggled 1,0,1, then switch to mode = 00 on the same cycle as the third byte -> exactly 2 writes plus the trailing third write. cpu_rst_n = 0 for one cycle after exit, then 1.
- Step: mode = 01, step_btn held high for 10 cycles -> exactly one cpu_ce pulse, 1 cycle wide, 1 cycle after the edge. Three separate presses -> 3 pulses.
- Run: DIV_W = 3, mode = 10 for 40 cycles -> cpu_ce pulses every 8 cycles, first pulse 8 cycles after entry.
- ena gating: in RUN, drop ena for 20 cycles -> no cpu_ce, divider frozen. After ena returns, the remaining count completes before the next pulse.

Source files
------------

// File: rtl/td4_run_ctrl.sv
// Run/load controller for the TD4 core: owns the CPU clock-enable and soft reset,
// and streams bytes into the 16x8 program memory over a valid/ready handshake.
module td4_run_ctrl #(
    parameter int DIV_W = 20,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_ena,
    input  logic [1:0]    i_mode,
    input  logic          i_step_btn,
    input  logic          i_ld_valid,
    input  logic [7:0]    i_ld_data,
    output logic          o_ld_ready,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [7:0]    o_mem_wdata,
    output logic          o_cpu_ce,
    output logic          o_cpu_rst_n,
    output logic [1:0]    o_state
);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_STEP = 2'd1,
        ST_RUN  = 2'd2,
        ST_LOAD = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   w_div_nxt;
    logic [AW-1:0]      r_addr;
    logic [AW-1:0]      w_addr_nxt;
    logic               r_step_q;
    logic               r_ld_ready;
    logic               r_mem_we;
    logic [AW-1:0]      r_mem_addr;
    logic [7:0]         r_mem_wdata;
    logic               r_cpu_ce;
    logic               r_cpu_rst_n;
    logic               w_hs;
    logic               w_ce_nxt;
    logic               w_ld_ready_nxt;
    logic               w_rst_n_nxt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HALT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next values of all registered outputs; ena low freezes everything
    always_comb begin
        w_state_nxt    = r_state;
        w_hs           = 1'b0;
        w_ce_nxt       = 1'b0;
        w_div_nxt      = r_div;
        w_addr_nxt     = r_addr;
        w_ld_ready_nxt = 1'b0;
        w_rst_n_nxt    = r_cpu_rst_n;
        if (i_ena) begin
            w_state_nxt    = state_t'(i_mode);
            w_hs           = i_ld_valid & r_ld_ready;
            w_ld_ready_nxt = (w_state_nxt == ST_LOAD);
            // Held low through LOAD and for one cycle after it, so the CPU restarts at PC 0
            w_rst_n_nxt    = (w_state_nxt != ST_LOAD) && (r_state != ST_LOAD);
            case (r_state)
                ST_STEP: w_ce_nxt = i_step_btn & ~r_step_q;
                ST_RUN:  w_ce_nxt = &r_div;
                default: w_ce_nxt = 1'b0;
            endcase
            if ((r_state == ST_RUN) && (w_state_nxt == ST_RUN)) begin
                w_div_nxt = r_div + DIV_W'(1);
            end else begin
                w_div_nxt = '0;
            end
            if ((r_state != ST_LOAD) && (w_state_nxt == ST_LOAD)) begin
                w_addr_nxt = '0;
            end else if (w_hs) begin
                w_addr_nxt = (r_addr == LAST_ADDR) ? '0 : r_addr + AW'(1);
            end else begin
                w_addr_nxt = r_addr;
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Counters, edge register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div       <= '0;
            r_addr      <= '0;
            r_step_q    <= 1'b0;
            r_ld_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'h00;
            r_cpu_ce    <= 1'b0;
            r_cpu_rst_n <= 1'b0;
        end else begin
            r_div       <= w_div_nxt;
            r_addr      <= w_addr_nxt;
            r_step_q    <= i_step_btn;
            r_ld_ready  <= w_ld_ready_nxt;
            r_mem_we    <= w_hs;
            r_cpu_ce    <= w_ce_nxt;
            r_cpu_rst_n <= w_rst_n_nxt;
            if (w_hs) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= i_ld_data;
            end else begin
                r_mem_addr  <= r_mem_addr;
                r_mem_wdata <= r_mem_wdata;
            end
        end
    end

    assign o_ld_ready  = r_ld_ready;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_cpu_ce    = r_cpu_ce;
    assign o_cpu_rst_n = r_cpu_rst_n;
    assign o_state     = r_state;

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Self-checking bench for td4_run_ctrl: directed scenarios plus random stimulus,
// every cycle compared against a behavioural model of the controller.
module tb_td4_run_ctrl;

    localparam int DIV_W  = 3;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int PERIOD = 1 << DIV_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic [1:0]    mode;
    logic          step_btn;
    logic          ld_valid;
    logic [7:0]    ld_data;
    logic          ld_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          cpu_ce;
    logic          cpu_rst_n;
    logic [1:0]    state_o;

    td4_run_ctrl #(.DIV_W(DIV_W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_ena       (ena),
        .i_mode      (mode),
        .i_step_btn  (step_btn),
        .i_ld_valid  (ld_valid),
        .i_ld_data   (ld_data),
        .o_ld_ready  (ld_ready),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_cpu_ce    (cpu_ce),
        .o_cpu_rst_n (cpu_rst_n),
        .o_state     (state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int ce_cnt   = 0;
    int we_cnt   = 0;

    // Reference model: mode, cycles spent in RUN, load pointer, expected outputs
    int m_state;
    int m_run_cnt;
    int m_addr;
    bit m_prev_btn;
    bit e_ld_ready, e_we, e_ce, e_rstn;
    int e_addr, e_wdata;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state    = 0;
        m_run_cnt  = 0;
        m_addr     = 0;
        m_prev_btn = 1'b0;
        e_ld_ready = 1'b0;
        e_we       = 1'b0;
        e_ce       = 1'b0;
        e_rstn     = 1'b0;
        e_addr     = 0;
        e_wdata    = 0;
    endtask

    // Predicts the outputs after the coming edge from the inputs now applied
    task automatic model_edge();
        int nxt;
        bit hs;
        if (ena) begin
            nxt  = int'(mode);
            hs   = ld_valid && e_ld_ready;
            e_ce = 1'b0;
            if (m_state == 1) e_ce = step_btn && !m_prev_btn;
            if (m_state == 2) begin
                m_run_cnt++;
                e_ce = ((m_run_cnt % PERIOD) == 0);
            end
            if (nxt == 2 && m_state != 2) m_run_cnt = 0;
            e_we = hs;
            if (hs) begin
                e_addr  = m_addr;
                e_wdata = int'(ld_data);
                m_addr  = (m_addr + 1) % DEPTH;
            end
            if (nxt == 3 && m_state != 3) m_addr = 0;
            e_ld_ready = (nxt == 3);
            e_rstn     = (nxt != 3) && (m_state != 3);
            m_state    = nxt;
        end else begin
            e_ce       = 1'b0;
            e_we       = 1'b0;
            e_ld_ready = 1'b0;
        end
        m_prev_btn = step_btn;
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check_eq("state_o",   32'(state_o),   32'(m_state));
        check_eq("ld_ready",  32'(ld_ready),  32'(e_ld_ready));
        check_eq("mem_we",    32'(mem_we),    32'(e_we));
        check_eq("mem_addr",  32'(mem_addr),  32'(e_addr));
        check_eq("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
        check_eq("cpu_ce",    32'(cpu_ce),    32'(e_ce));
        check_eq("cpu_rst_n", 32'(cpu_rst_n), 32'(e_rstn));
        ce_cnt += int'(cpu_ce);
        we_cnt += int'(mem_we);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_state_o",   32'(state_o),   32'd0);
        check_eq("rst_ld_ready",  32'(ld_ready),  32'd0);
        check_eq("rst_mem_we",    32'(mem_we),    32'd0);
        check_eq("rst_mem_addr",  32'(mem_addr),  32'd0);
        check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check_eq("rst_cpu_ce",    32'(cpu_ce),    32'd0);
        check_eq("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b1;
        mode     = 2'b10;
        step_btn = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        model_reset();
        cyc();

        // Back-to-back load of 16 bytes, then a 17th that wraps onto word 0
        mode = 2'b11;
        cyc();
        we_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'h30 + 8'(i);
            cyc();
        end
        ld_data = 8'hAA;
        cyc();
        ld_valid = 1'b0;
        cyc();
        check_eq("load_write_count", 32'(we_cnt), 32'd17);

        // Gapped handshake, leaving LOAD on the cycle of the third byte
        mode = 2'b00;
        cyc();
        mode = 2'b11;
        cyc();
        we_cnt = 0;
        ld_valid = 1'b1; ld_data = 8'h51; cyc();
        ld_valid = 1'b0; cyc();
        ld_valid = 1'b1; ld_data = 8'h52; cyc();
        ld_valid = 1'b0; cyc();
        ld_valid = 1'b1; ld_data = 8'h53; mode = 2'b00; cyc();
        ld_valid = 1'b0;
        cyc();
        cyc();
        check_eq("gap_write_count", 32'(we_cnt), 32'd3);

        // Single step: held button, then three separate presses
        mode = 2'b01;
        cyc();
        cyc();
        ce_cnt   = 0;
        step_btn = 1'b1;
        repeat (10) cyc();
        step_btn = 1'b0;
        cyc();
        cyc();
        check_eq("step_held_pulses", 32'(ce_cnt), 32'd1);
        ce_cnt = 0;
        for (int p = 0; p < 3; p++) begin
            step_btn = 1'b1; cyc(); cyc();
            step_btn = 1'b0; cyc(); cyc();
        end
        check_eq("step_three_pulses", 32'(ce_cnt), 32'd3);

        // Free run: first pulse 8 cycles after entry, then every 8
        mode   = 2'b10;
        ce_cnt = 0;
        repeat (40) cyc();
        check_eq("run_pulses_40", 32'(ce_cnt), 32'd4);

        // ena gating freezes the divider; the remaining count completes afterwards
        repeat (3) cyc();
        ce_cnt = 0;
        ena    = 1'b0;
        repeat (20) cyc();
        check_eq("ena_low_pulses", 32'(ce_cnt), 32'd0);
        ena    = 1'b1;
        ce_cnt = 0;
        repeat (20) cyc();
        check_eq("ena_resume_pulses", 32'(ce_cnt), 32'd2);

        // Random mode, ena, button and load traffic
        for (int r = 0; r < 600; r++) begin
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            ena      = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) step_btn = ~step_btn;
            ld_valid = 1'($urandom_range(0, 1));
            ld_data  = 8'($urandom_range(0, 255));
            cyc();
        end

        // Reset in the middle of a load restarts the loader at address 0
        ena      = 1'b1;
        step_btn = 1'b0;
        mode     = 2'b11;
        ld_valid = 1'b0;
        cyc();
        cyc();
        ld_valid = 1'b1;
        ld_data  = 8'h11;
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        ld_data = 8'h77;
        cyc();
        cyc();
        ld_valid = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
